// File: rtl/udp_table_seq_eval.sv
// Run-time loadable UDP truth/state table evaluator. A table indexed by {q, previous inputs,
// current inputs} yields the next q (0, 1, hold or x); one sample per cycle, one cycle latency.
module udp_table_seq_eval #(
  parameter int unsigned N_IN   = 2,
  parameter bit          SEQ    = 1'b1,
  parameter bit          INIT_Q = 1'b0,
  localparam int unsigned AW    = 1 + 2 * N_IN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cfg_start,
  input  logic            i_cfg_we,
  input  logic [AW-1:0]   i_cfg_addr,
  input  logic [1:0]      i_cfg_data,
  input  logic            i_cfg_done,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [N_IN-1:0] i_in_data,
  output logic            o_out_valid,
  output logic            o_out_q,
  output logic            o_out_x,
  output logic            o_busy_cfg
);

  localparam int unsigned Depth = 1 << AW;

  typedef enum logic [1:0] {StUncfg, StLoad, StRun} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [1:0]      r_table [Depth];
  logic            r_q;
  logic            r_out_valid;
  logic            r_out_x;
  logic [N_IN-1:0] r_prev;
  logic            r_first;

  logic [N_IN-1:0] w_prev;
  logic [AW-1:0]   w_idx;
  logic [1:0]      w_code;
  logic            w_accept;
  logic            w_load_to_run;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StUncfg;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; in LOAD cfg_done takes priority over cfg_start
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StUncfg: if (i_cfg_start) w_state_next = StLoad;
      StLoad:  if (i_cfg_done)  w_state_next = StRun;
      StRun:   if (i_cfg_start) w_state_next = StLoad;
      default: w_state_next = StUncfg;
    endcase
  end

  // Output decode, purely from state
  always_comb begin
    o_in_ready = 1'b0;
    o_busy_cfg = 1'b0;
    unique case (r_state)
      StLoad:  o_busy_cfg = 1'b1;
      StRun:   o_in_ready = 1'b1;
      default: ;
    endcase
  end

  assign w_accept      = i_in_valid & o_in_ready;
  assign w_load_to_run = (r_state == StLoad) & i_cfg_done;

  // The first sample after (re)start sees prev == current, so it can never look like an edge.
  assign w_prev = r_first ? i_in_data : r_prev;

  always_comb begin
    if (SEQ) begin
      w_idx = {r_q, w_prev, i_in_data};
    end else begin
      w_idx = {{(AW - N_IN){1'b0}}, i_in_data};
    end
  end

  assign w_code = r_table[w_idx];

  // Table survives reset; only written while loading
  always_ff @(posedge i_clk) begin
    if (!i_rst && (r_state == StLoad) && i_cfg_we) begin
      r_table[i_cfg_addr] <= i_cfg_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q         <= INIT_Q;
      r_out_valid <= 1'b0;
      r_out_x     <= 1'b0;
      r_prev      <= '0;
      r_first     <= 1'b1;
    end else begin
      r_out_valid <= w_accept;
      r_out_x     <= w_accept && (w_code == 2'b11);
      if (w_load_to_run) begin
        r_q     <= INIT_Q;
        r_first <= 1'b1;
      end else if (w_accept) begin
        case (w_code)
          2'b00:   r_q <= 1'b0;
          2'b01:   r_q <= 1'b1;
          default: r_q <= r_q;
        endcase
        r_prev  <= i_in_data;
        r_first <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_q     = r_q;
  assign o_out_x     = r_out_x;

endmodule

// File: tb/tb_udp_table_seq_eval.sv
// Bench for udp_table_seq_eval: a sequential 2-input instance (D flop) and a combinational
// 1-input instance (inverter), each checked through an expected-result queue.
module tb_udp_table_seq_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       s_cfg_start, s_cfg_we, s_cfg_done, s_in_valid;
  logic [4:0] s_cfg_addr;
  logic [1:0] s_cfg_data;
  logic [1:0] s_in_data;
  logic       s_in_ready, s_out_valid, s_out_q, s_out_x, s_busy;

  logic       c_cfg_start, c_cfg_we, c_cfg_done, c_in_valid;
  logic [2:0] c_cfg_addr;
  logic [1:0] c_cfg_data;
  logic [0:0] c_in_data;
  logic       c_in_ready, c_out_valid, c_out_q, c_out_x, c_busy;

  udp_table_seq_eval #(.N_IN(2), .SEQ(1'b1), .INIT_Q(1'b0)) u_seq (
    .i_clk(clk), .i_rst(rst), .i_cfg_start(s_cfg_start), .i_cfg_we(s_cfg_we),
    .i_cfg_addr(s_cfg_addr), .i_cfg_data(s_cfg_data), .i_cfg_done(s_cfg_done),
    .i_in_valid(s_in_valid), .o_in_ready(s_in_ready), .i_in_data(s_in_data),
    .o_out_valid(s_out_valid), .o_out_q(s_out_q), .o_out_x(s_out_x), .o_busy_cfg(s_busy)
  );

  udp_table_seq_eval #(.N_IN(1), .SEQ(1'b0), .INIT_Q(1'b0)) u_comb (
    .i_clk(clk), .i_rst(rst), .i_cfg_start(c_cfg_start), .i_cfg_we(c_cfg_we),
    .i_cfg_addr(c_cfg_addr), .i_cfg_data(c_cfg_data), .i_cfg_done(c_cfg_done),
    .i_in_valid(c_in_valid), .o_in_ready(c_in_ready), .i_in_data(c_in_data),
    .o_out_valid(c_out_valid), .o_out_q(c_out_q), .o_out_x(c_out_x), .o_busy_cfg(c_busy)
  );

  typedef struct {
    logic q;
    logic x;
    int   due;
  } exp_t;

  typedef struct {
    logic [1:0] din;
    logic       eq;
    logic       ex;
  } vec_t;

  exp_t sq[$];
  exp_t cq[$];
  exp_t s_e, c_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: every result must match the queue head and arrive on its due cycle.
  always @(negedge clk) begin
    if (s_out_valid) begin
      if (sq.size() == 0) begin
        chk("seq_spurious_valid", s_out_valid, 0);
      end else begin
        s_e = sq.pop_front();
        chk("seq_out_q", s_out_q, s_e.q);
        chk("seq_out_x", s_out_x, s_e.x);
        chk("seq_latency", cyc, s_e.due);
      end
    end else if (sq.size() > 0 && sq[0].due <= cyc) begin
      chk("seq_missing_valid", s_out_valid, 1);
      void'(sq.pop_front());
    end else begin
      chk("seq_idle_out_x", s_out_x, 0);
    end
  end

  always @(negedge clk) begin
    if (c_out_valid) begin
      if (cq.size() == 0) begin
        chk("comb_spurious_valid", c_out_valid, 0);
      end else begin
        c_e = cq.pop_front();
        chk("comb_out_q", c_out_q, c_e.q);
        chk("comb_out_x", c_out_x, c_e.x);
        chk("comb_latency", cyc, c_e.due);
      end
    end else if (cq.size() > 0 && cq[0].due <= cyc) begin
      chk("comb_missing_valid", c_out_valid, 1);
      void'(cq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seq_cfg_start();
    s_cfg_start = 1'b1;
    tick();
    s_cfg_start = 1'b0;
  endtask

  task automatic seq_write(input logic [4:0] a, input logic [1:0] d, input logic done);
    s_cfg_we   = 1'b1;
    s_cfg_addr = a;
    s_cfg_data = d;
    s_cfg_done = done;
    tick();
    s_cfg_we   = 1'b0;
    s_cfg_done = 1'b0;
  endtask

  task automatic seq_send(input logic [1:0] d, input logic eq, input logic ex,
                          input logic with_start);
    s_in_valid  = 1'b1;
    s_in_data   = d;
    s_cfg_start = with_start;
    sq.push_back('{q: eq, x: ex, due: cyc + 1});
    tick();
    s_in_valid  = 1'b0;
    s_cfg_start = 1'b0;
  endtask

  task automatic comb_write(input logic [2:0] a, input logic [1:0] d, input logic done);
    c_cfg_we   = 1'b1;
    c_cfg_addr = a;
    c_cfg_data = d;
    c_cfg_done = done;
    tick();
    c_cfg_we   = 1'b0;
    c_cfg_done = 1'b0;
  endtask

  // Rising-edge D flop: idx = {q, prev_clk, prev_d, cur_clk, cur_d}
  function automatic logic [1:0] dff_code(input int a);
    logic [4:0] i;
    i = a[4:0];
    if (!i[3] && i[1]) return {1'b0, i[0]};
    return 2'b10;
  endfunction

  vec_t inv_vec[4];
  vec_t dff_vec[5];
  vec_t ret_vec[4];

  initial begin
    inv_vec[0] = '{din: 2'd0, eq: 1'b1, ex: 1'b0};
    inv_vec[1] = '{din: 2'd1, eq: 1'b0, ex: 1'b0};
    inv_vec[2] = '{din: 2'd1, eq: 1'b0, ex: 1'b0};
    inv_vec[3] = '{din: 2'd0, eq: 1'b1, ex: 1'b0};
    dff_vec[0] = '{din: 2'b01, eq: 1'b0, ex: 1'b0};
    dff_vec[1] = '{din: 2'b11, eq: 1'b1, ex: 1'b0};
    dff_vec[2] = '{din: 2'b10, eq: 1'b1, ex: 1'b0};
    dff_vec[3] = '{din: 2'b00, eq: 1'b1, ex: 1'b0};
    dff_vec[4] = '{din: 2'b10, eq: 1'b0, ex: 1'b0};
    ret_vec[0] = '{din: 2'b00, eq: 1'b0, ex: 1'b0};
    ret_vec[1] = '{din: 2'b11, eq: 1'b1, ex: 1'b0};
    ret_vec[2] = '{din: 2'b00, eq: 1'b1, ex: 1'b0};
    ret_vec[3] = '{din: 2'b10, eq: 1'b0, ex: 1'b0};

    {s_cfg_start, s_cfg_we, s_cfg_done, s_in_valid} = '0;
    {c_cfg_start, c_cfg_we, c_cfg_done, c_in_valid} = '0;
    s_cfg_addr = '0; s_cfg_data = '0; s_in_data = '0;
    c_cfg_addr = '0; c_cfg_data = '0; c_in_data = '0;

    // Reset held for two cycles
    rst = 1'b1;
    tick();
    tick();
    chk("rst_seq_ready", s_in_ready, 0);
    chk("rst_seq_valid", s_out_valid, 0);
    chk("rst_seq_q", s_out_q, 0);
    chk("rst_seq_busy", s_busy, 0);
    chk("rst_comb_ready", c_in_ready, 0);
    chk("rst_comb_q", c_out_q, 0);
    rst = 1'b0;
    tick();

    // Combinational inverter; last write shares the cycle with cfg_done
    c_cfg_start = 1'b1;
    tick();
    c_cfg_start = 1'b0;
    chk("comb_load_busy", c_busy, 1);
    chk("comb_load_ready", c_in_ready, 0);
    comb_write(3'd0, 2'b01, 1'b0);
    comb_write(3'd1, 2'b00, 1'b1);
    chk("comb_run_ready", c_in_ready, 1);
    chk("comb_run_busy", c_busy, 0);
    for (int k = 0; k < 4; k++) begin
      c_in_valid = 1'b1;
      c_in_data  = inv_vec[k].din[0:0];
      cq.push_back('{q: inv_vec[k].eq, x: inv_vec[k].ex, due: cyc + 1});
      tick();
    end
    c_in_valid = 1'b0;
    tick();

    // Sequential rising-edge D flop
    seq_cfg_start();
    chk("seq_load_busy", s_busy, 1);
    for (int a = 0; a < 32; a++) seq_write(a[4:0], dff_code(a), a == 31);
    chk("seq_run_ready", s_in_ready, 1);
    for (int k = 0; k < 5; k++) seq_send(dff_vec[k].din, dff_vec[k].eq, dff_vec[k].ex, 1'b0);
    tick();

    // x entry at idx 5: out_x for one sample, q unchanged
    seq_cfg_start();
    seq_write(5'd5, 2'b11, 1'b1);
    seq_send(2'b01, 1'b0, 1'b1, 1'b0);
    seq_send(2'b11, 1'b1, 1'b0, 1'b0);
    tick();
    chk("x_clears", s_out_x, 0);

    // Reload with a sample offered on the cfg_start cycle: it is still accepted
    seq_send(2'b00, 1'b1, 1'b0, 1'b1);
    chk("reload_ready_low", s_in_ready, 0);
    chk("reload_busy", s_busy, 1);
    s_in_valid = 1'b1;
    s_in_data  = 2'b11;
    tick();
    s_in_valid = 1'b0;
    chk("reload_q_held", s_out_q, 1);
    seq_write(5'd5, 2'b01, 1'b1);
    chk("reload_q_init", s_out_q, 0);
    chk("reload_ready_high", s_in_ready, 1);
    seq_send(2'b01, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream discards the pending sample but keeps the table
    s_in_valid = 1'b1;
    s_in_data  = 2'b11;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_in_valid = 1'b0;
    chk("midrst_valid", s_out_valid, 0);
    chk("midrst_ready", s_in_ready, 0);
    chk("midrst_busy", s_busy, 0);
    chk("midrst_q", s_out_q, 0);
    seq_cfg_start();
    s_cfg_done = 1'b1;
    tick();
    s_cfg_done = 1'b0;
    for (int k = 0; k < 4; k++) seq_send(ret_vec[k].din, ret_vec[k].eq, ret_vec[k].ex, 1'b0);

    tick();
    tick();
    chk("seq_queue_drained", sq.size(), 0);
    chk("comb_queue_drained", cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
